// File: rtl/elastic_pipe_stage_pkg.sv
// elastic_pipe_stage_pkg: shared defaults and handshake op encoding for elastic stages
package elastic_pipe_stage_pkg;
   localparam int PIPE_DEPTH_DEFAULT = 2;
   localparam int PIPE_DATA_W_DEFAULT = 32;
   typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_BOTH} op_e;
   function automatic op_e classify(input logic push, input logic pop);
      return op_e'({pop, push});
   endfunction
endpackage

// File: rtl/elastic_pipe_stage_if.sv
// elastic_pipe_stage_if: valid/ready bundle plus flush and occupancy for one elastic stage
interface elastic_pipe_stage_if
   import elastic_pipe_stage_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W_DEFAULT,
   parameter int DEPTH = PIPE_DEPTH_DEFAULT
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic in_valid, in_ready, out_valid, out_ready, flush;
   logic [DATA_W-1:0] in_data, out_data;
   logic [CNT_W-1:0] count;
   modport master (
      output in_valid, in_data, out_ready, flush,
      input in_ready, out_valid, out_data, count
   );
   modport slave (
      input in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/elastic_pipe_stage.sv
// elastic_pipe_stage: circular skid buffer with registered ready, flush and zero bubble output
module elastic_pipe_stage
   import elastic_pipe_stage_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W_DEFAULT,
   parameter int DEPTH = PIPE_DEPTH_DEFAULT,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input logic CLK,
   input logic nRST,
   elastic_pipe_stage_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic push, pop;
   op_e op;
   always_comb begin
      push = bus.in_valid & bus.in_ready & ~bus.flush;
      pop = bus.out_valid & bus.out_ready & ~bus.flush;
      op = classify(push, pop);
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d = bus.flush ? '0 : wr_ptr_q + PTR_W'(push);
      rd_ptr_d = bus.flush ? '0 : rd_ptr_q + PTR_W'(pop);
      count_d = bus.flush ? '0 :
                op == OP_PUSH ? count_q + 1'b1 :
                op == OP_POP ? count_q - 1'b1 : count_q;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         mem_q <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
      end
   end
   // ready comes only from the registered count, so a downstream stall never reaches upstream combinationally
   assign bus.in_ready = count_q != FULL;
   assign bus.out_valid = count_q != '0;
   assign bus.out_data = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.count = count_q;
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// tb_elastic_pipe_stage: scoreboard bench for a DEPTH=2/32-bit and a DEPTH=4/8-bit stage
module tb_elastic_pipe_stage;
   logic CLK = 0;
   logic nRST = 0;
   int total = 0;
   int bad = 0;
   int pops4 = 0;
   logic [31:0] q2[$];
   logic [7:0] q4[$];
   elastic_pipe_stage_if #(.DATA_W(32), .DEPTH(2)) b2();
   elastic_pipe_stage_if #(.DATA_W(8), .DEPTH(4)) b4();
   elastic_pipe_stage #(.DATA_W(32), .DEPTH(2)) u2 (.CLK(CLK), .nRST(nRST), .bus(b2.slave));
   elastic_pipe_stage #(.DATA_W(8), .DEPTH(4)) u4 (.CLK(CLK), .nRST(nRST), .bus(b4.slave));
   always #5 CLK = ~CLK;

   task automatic step(output logic acc4);
      int sz;
      logic [31:0] e2;
      logic [7:0] e4;
      sz = q2.size();
      total++; if (b2.out_valid !== (sz != 0)) begin bad++; $display("FAIL d2_out_valid got=%0b exp=%0b", b2.out_valid, sz != 0); end
      total++; if (b2.in_ready !== (sz != 2)) begin bad++; $display("FAIL d2_in_ready got=%0b exp=%0b", b2.in_ready, sz != 2); end
      total++; if (b2.count !== sz) begin bad++; $display("FAIL d2_count got=%0d exp=%0d", b2.count, sz); end
      if (sz == 0) begin
         total++; if (b2.out_data !== 32'h0) begin bad++; $display("FAIL d2_bubble got=%0h exp=0", b2.out_data); end
      end
      if (b2.flush) q2.delete();
      else begin
         if (b2.out_ready && sz != 0) begin
            e2 = q2.pop_front();
            total++; if (b2.out_data !== e2) begin bad++; $display("FAIL d2_data got=%0h exp=%0h", b2.out_data, e2); end
         end
         if (b2.in_valid && sz != 2) q2.push_back(b2.in_data);
      end
      sz = q4.size();
      acc4 = 0;
      total++; if (b4.out_valid !== (sz != 0)) begin bad++; $display("FAIL d4_out_valid got=%0b exp=%0b", b4.out_valid, sz != 0); end
      total++; if (b4.in_ready !== (sz != 4)) begin bad++; $display("FAIL d4_in_ready got=%0b exp=%0b", b4.in_ready, sz != 4); end
      total++; if (b4.count !== sz) begin bad++; $display("FAIL d4_count got=%0d exp=%0d", b4.count, sz); end
      if (b4.flush) q4.delete();
      else begin
         if (b4.out_ready && sz != 0) begin
            e4 = q4.pop_front();
            pops4++;
            total++; if (b4.out_data !== e4) begin bad++; $display("FAIL d4_data got=%0h exp=%0h", b4.out_data, e4); end
         end
         if (b4.in_valid && sz != 4) begin q4.push_back(b4.in_data); acc4 = 1; end
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      #1;
      total++; if (b2.count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", b2.count); end
      total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", b2.out_valid); end
      total++; if (b2.out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%0h exp=0", b2.out_data); end
      total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", b2.in_ready); end
      #11 nRST = 1;
   endtask

   task automatic test_streaming();
      logic a;
      logic [31:0] d [3] = '{32'h11, 32'h22, 32'h33};
      b2.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         b2.in_valid = 1;
         b2.in_data = d[i];
         step(a);
         total++; if (b2.count !== 2'd1) begin bad++; $display("FAIL stream_count got=%0d exp=1", b2.count); end
      end
      b2.in_valid = 0;
      step(a);
      total++; if (q2.size() != 0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", q2.size()); end
   endtask

   task automatic test_backpressure();
      logic a;
      logic [31:0] d [3] = '{32'hA, 32'hB, 32'hC};
      b2.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         b2.in_valid = 1;
         b2.in_data = d[i];
         step(a);
      end
      total++; if (b2.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", b2.in_ready); end
      b2.in_valid = 0;
      b2.out_ready = 1;
      step(a);
      total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%0b exp=1", b2.in_ready); end
      step(a);
      total++; if (q2.size() != 0) begin bad++; $display("FAIL bp_drain got=%0d exp=0", q2.size()); end
      b2.out_ready = 0;
   endtask

   task automatic test_flush();
      logic a;
      b2.out_ready = 0;
      b2.in_valid = 1;
      b2.in_data = 32'h51;
      step(a);
      b2.in_data = 32'h52;
      step(a);
      b2.flush = 1;
      b2.in_data = 32'h99;
      b2.out_ready = 1;
      step(a);
      total++; if (b2.count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", b2.count); end
      total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%0b exp=0", b2.out_valid); end
      total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0b exp=1", b2.in_ready); end
      b2.flush = 0;
      b2.in_valid = 0;
      step(a);
      total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL flush_word_lost got=%0b exp=0", b2.out_valid); end
      b2.out_ready = 0;
   endtask

   task automatic test_wrap();
      logic a;
      int n = 0;
      int cyc = 0;
      int maxc = 0;
      pops4 = 0;
      while ((n < 10 || q4.size() != 0) && cyc < 300) begin
         b4.in_valid = n < 10;
         b4.in_data = 8'(n + 1);
         b4.out_ready = 1'($urandom_range(0, 1));
         step(a);
         if (a) n++;
         if (int'(b4.count) > maxc) maxc = int'(b4.count);
         cyc++;
      end
      b4.in_valid = 0;
      b4.out_ready = 0;
      total++; if (pops4 != 10) begin bad++; $display("FAIL wrap_delivered got=%0d exp=10 cycles=%0d", pops4, cyc); end
      total++; if (maxc > 4) begin bad++; $display("FAIL wrap_max_count got=%0d exp<=4", maxc); end
   endtask

   task automatic test_bubble();
      logic a;
      b2.in_valid = 0;
      b2.out_ready = 1;
      for (int i = 0; i < 3; i++) begin
         step(a);
         total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%0b exp=0", b2.out_valid); end
         total++; if (b2.out_data !== 32'h0) begin bad++; $display("FAIL bubble_data got=%0h exp=0", b2.out_data); end
      end
      b2.out_ready = 0;
   endtask

   task automatic test_reset_midrun();
      logic a;
      b2.out_ready = 0;
      b2.in_valid = 1;
      b2.in_data = 32'h71;
      step(a);
      b2.in_data = 32'h72;
      step(a);
      b2.in_valid = 0;
      total++; if (b2.count !== 2'd2) begin bad++; $display("FAIL mid_pre_count got=%0d exp=2", b2.count); end
      #1 nRST = 0;
      #1;
      total++; if (b2.count !== 2'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", b2.count); end
      total++; if (b2.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", b2.out_valid); end
      total++; if (b2.out_data !== 32'h0) begin bad++; $display("FAIL mid_rst_data got=%0h exp=0", b2.out_data); end
      total++; if (b2.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=1", b2.in_ready); end
      q2.delete();
      q4.delete();
      #1 nRST = 1;
      step(a);
   endtask

   initial begin
      b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 0; b2.flush = 0;
      b4.in_valid = 0; b4.in_data = '0; b4.out_ready = 0; b4.flush = 0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wrap();
      test_bubble();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
